// File: rtl/cosim_test_sequencer.sv
// Run controller for the AND-gate co-simulation: pulls vectors from a source, drives the DUT,
// checks its output after a fixed latency and reports vector/error counts and pass/fail.
module cosim_test_sequencer #(
  parameter int unsigned DUT_LATENCY    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             src_valid,
  input  logic             src_a,
  input  logic             src_b,
  input  logic             src_exp,
  input  logic             src_last,
  output logic             src_ready,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_valid,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam int DEPTH   = DUT_LATENCY + 1;
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [DEPTH-1:0]   OUT_STAGE  = DEPTH'(1) << DUT_LATENCY;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               timeout_q, timeout_d;
  logic               dut_a_q, dut_a_d;
  logic               dut_b_q, dut_b_d;
  logic               dut_valid_q, dut_valid_d;

  // Check delay line: stage DEPTH-1 lines up with dut_y for the vector it carries.
  logic [DEPTH-1:0]   pipe_vld_q;
  logic [DEPTH-1:0]   pipe_exp_q;
  logic [CNT_W-1:0]   pipe_idx_q [DEPTH];

  logic accept, restart, stall_hit, flush, mismatch, drain_empty;

  assign src_ready   = (state_q == S_RUN) & ~abort;
  assign accept      = src_ready & src_valid;
  assign restart     = start & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign stall_hit   = src_ready & ~src_valid & (stall_q == STALL_LAST);
  assign flush       = abort | stall_hit;
  assign mismatch    = pipe_vld_q[DEPTH-1] & ~flush & (dut_y != pipe_exp_q[DEPTH-1]);
  // Drain is complete once only the output stage can still hold a pending check.
  assign drain_empty = ~|(pipe_vld_q & ~OUT_STAGE);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    stall_d     = '0;
    vec_d       = vec_q;
    err_d       = err_q;
    first_d     = first_q;
    timeout_d   = timeout_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    dut_valid_d = accept;

    if (accept) begin
      dut_a_d = src_a;
      dut_b_d = src_b;
      if (vec_q != CNT_MAX) vec_d = vec_q + 1'b1;
    end
    if (src_ready && !src_valid && !stall_hit) stall_d = stall_q + 1'b1;

    if (mismatch) begin
      if (err_q != CNT_MAX) err_d = err_q + 1'b1;
      if (err_q == '0) first_d = pipe_idx_q[DEPTH-1];
    end

    unique case (state_q)
      S_IDLE:  if (restart) state_d = S_RUN;
      S_RUN: begin
        if (abort) state_d = S_IDLE;
        else if (stall_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (accept && src_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) state_d = S_IDLE;
        else if (drain_empty) state_d = S_DONE;
      end
      S_DONE: begin
        if (abort) state_d = S_IDLE;
        else if (restart) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) timeout_d = 1'b0;
    if (restart) begin
      vec_d     = '0;
      err_d     = '0;
      first_d   = '0;
      timeout_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stall_q     <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      first_q     <= '0;
      timeout_q   <= 1'b0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      dut_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      first_q     <= first_d;
      timeout_q   <= timeout_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      dut_valid_q <= dut_valid_d;
    end
  end

  // NOTE: the delay line is a handful of flops, so data stages are reset along with the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_exp_q <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_idx_q[i] <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] & ~flush;
        pipe_exp_q[i] <= pipe_exp_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
      pipe_vld_q[0] <= accept;
      pipe_exp_q[0] <= src_exp;
      pipe_idx_q[0] <= vec_q;
    end
  end

  assign dut_a         = dut_a_q;
  assign dut_b         = dut_b_q;
  assign dut_valid     = dut_valid_q;
  assign busy          = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done & ~timeout_q & (err_q == '0) & (vec_q != '0);
  assign timeout       = timeout_q;
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule
